// File: rtl/fifo_pixel_streamer.sv
// Pixel FIFO consumer: prefetches into a 2-entry skid buffer and emits a framed stream.
// Optional starvation counter enabled by defining STREAM_UNDERRUN_CNT_EN.
module fifo_pixel_streamer #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] fifo_data_rd,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic              frame_start,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       underrun_count
);

    localparam int TOTAL = IMG_W * IMG_H;
    localparam int QW    = $clog2(TOTAL + 1);
    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [QW-1:0] REQ_MAX  = QW'(TOTAL);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] buf0;
    logic [DATA_W-1:0] buf1;
    logic              hd;
    logic [1:0]        occ;
    logic              inflight;
    logic [QW-1:0]     req_cnt;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;

    logic active;
    logic pop;
    logic tail;
    logic last_px;
    logic credit_ok;

    assign active  = (state == ACTIVE);
    assign m_valid = (occ != 2'd0);
    assign m_data  = hd ? buf1 : buf0;
    assign pop     = m_valid && m_ready;
    assign tail    = hd ^ occ[0];
    assign last_px = (col == COL_LAST) && (row == ROW_LAST);
    assign busy    = active;

    // Entries held or on their way must stay within the two buffer slots.
    assign credit_ok = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

    assign fifo_rd_en = active && !fifo_empty && (req_cnt < REQ_MAX) && credit_ok;

    assign m_sof = m_valid && (col == '0) && (row == '0);
    assign m_eol = m_valid && (col == COL_LAST);
    assign m_eof = m_eol && (row == ROW_LAST);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            buf0       <= '0;
            buf1       <= '0;
            hd         <= 1'b0;
            occ        <= 2'd0;
            inflight   <= 1'b0;
            req_cnt    <= '0;
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (frame_start) begin
                        state    <= ACTIVE;
                        req_cnt  <= '0;
                        col      <= '0;
                        row      <= '0;
                        occ      <= 2'd0;
                        inflight <= 1'b0;
                        hd       <= 1'b0;
                    end
                end
                ACTIVE: begin
                    inflight <= fifo_rd_en;
                    if (fifo_rd_en) begin
                        req_cnt <= req_cnt + QW'(1);
                    end
                    if (inflight) begin
                        if (tail) buf1 <= fifo_data_rd;
                        else      buf0 <= fifo_data_rd;
                    end
                    unique case ({inflight, pop})
                        2'b10:   occ <= occ + 2'd1;
                        2'b01:   occ <= occ - 2'd1;
                        default: occ <= occ;
                    endcase
                    if (pop) begin
                        hd <= ~hd;
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= row + RW'(1);
                        end else begin
                            col <= col + CW'(1);
                        end
                        if (last_px) begin
                            state      <= IDLE;
                            frame_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STREAM_UNDERRUN_CNT_EN
    logic [1:0]  warm;
    logic [15:0] urun;

    // The first two active cycles cannot have data yet, so they are not starvation.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            warm <= 2'd0;
            urun <= 16'd0;
        end else if (!active) begin
            if (frame_start) begin
                warm <= 2'd2;
                urun <= 16'd0;
            end
        end else if (warm != 2'd0) begin
            warm <= warm - 2'd1;
        end else if (m_ready && !m_valid && (urun != 16'hFFFF)) begin
            urun <= urun + 16'd1;
        end
    end

    assign underrun_count = urun;
`else
    assign underrun_count = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_pixel_streamer.sv
// Scoreboard bench for fifo_pixel_streamer with a behavioural FIFO and frame model.
module tb_fifo_pixel_streamer;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int N  = W * H;
    localparam int MS = 1024;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic [DW-1:0] fifo_data_rd = '0;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic          frame_start = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          m_sof;
    logic          m_eol;
    logic          m_eof;
    logic          busy;
    logic          frame_done;
    logic [15:0]   underrun_count;

    fifo_pixel_streamer #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk),
        .aresetn(aresetn),
        .fifo_data_rd(fifo_data_rd),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .frame_start(frame_start),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_sof(m_sof),
        .m_eol(m_eol),
        .m_eof(m_eof),
        .busy(busy),
        .frame_done(frame_done),
        .underrun_count(underrun_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sof;
        logic          eol;
        logic          eof;
    } pix_t;

    pix_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // FIFO model: mem staged by stimulus, wr_ptr publishes, rd_ptr consumes.
    logic [DW-1:0] mem [MS];
    int wr_ptr = 0;
    int sp = 0;
    int rd_ptr = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            chk("fifo_underflow", int'(fifo_empty), 0);
            if (!fifo_empty) begin
                fifo_data_rd <= mem[rd_ptr % MS];
                rd_ptr <= rd_ptr + 1;
            end
        end
    end

    // Downstream ready pattern generator.
    int rmode = 0;
    int pat = 0;
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: m_ready = 1'b1;
            1: begin
                m_ready = (pat == 0) || (pat == 3);
                pat = (pat + 1) % 4;
            end
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: scoreboard pops on every handshake plus protocol checks.
    int   cyc = 0;
    int   hs_cnt = 0;
    int   rd_cnt = 0;
    int   outst = 0;
    int   hs_cyc [MS];
    bit   stall = 0;
    bit   fd_exp = 0;
    logic [DW-1:0] stall_d = '0;

    always @(negedge clk) begin
        bit   hs;
        pix_t e;
        cyc++;
        if (!aresetn) begin
            exp_q.delete();
            stall = 0;
            fd_exp = 0;
            outst = 0;
        end else begin
            hs = m_valid && m_ready;
            chk("frame_done", int'(frame_done), int'(fd_exp));
            if (!busy) chk("idle_rd_en", int'(fifo_rd_en), 0);
            if (!m_valid) chk("flags_no_valid", int'({m_sof, m_eol, m_eof}), 0);
            if (stall) begin
                chk("stall_valid", int'(m_valid), 1);
                chk("stall_data", int'(m_data), int'(stall_d));
            end
            outst += int'(fifo_rd_en) - int'(hs);
            chk("buffer_credit", int'(outst <= 2), 1);
            if (fifo_rd_en) rd_cnt++;
            if (hs) begin
                chk("pixel_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("data", int'(m_data), int'(e.d));
                    chk("sof", int'(m_sof), int'(e.sof));
                    chk("eol", int'(m_eol), int'(e.eol));
                    chk("eof", int'(m_eof), int'(e.eof));
                end
                hs_cyc[hs_cnt % MS] = cyc;
                hs_cnt++;
            end
            stall = m_valid && !m_ready;
            stall_d = m_data;
            fd_exp = hs && m_eof;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic stage(input int n);
        for (int i = 0; i < n; i++) begin
            mem[sp % MS] = DW'($urandom);
            sp++;
        end
    endtask

    // Next frame is the next N FIFO words, framed by position.
    task automatic start_frame();
        for (int i = 0; i < N; i++) begin
            exp_q.push_back(pix_t'{mem[(rd_ptr + i) % MS], i == 0,
                                   (i % W) == W - 1, i == N - 1});
        end
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input bit dribble, input int budget);
        int k = 0;
        while ((busy || exp_q.size() != 0 || wr_ptr < sp) && k < budget) begin
            if (dribble && wr_ptr < sp && $urandom_range(0, 2) == 0) wr_ptr++;
            step();
            k++;
        end
        chk("frame_timeout", int'(k < budget), 1);
        step(2);
    endtask

    initial begin
        int hs0;
        int rd0;
        int k;
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int hs0;
        int rd0;
        int k;
        #2;
        chk("rst_valid", int'(m_valid), 0);
        chk("rst_data", int'(m_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_rd_en", int'(fifo_rd_en), 0);
        chk("rst_underrun", int'(underrun_count), 0);
        step(2);
        aresetn = 1'b1;
        step(2);

        // Preloaded frame at full rate.
        rmode = 0;
        stage(N);
        wr_ptr = sp;
        step();
        hs0 = hs_cnt;
        rd0 = rd_cnt;
        start_frame();
        chk("busy_on_start", int'(busy), 1);
        chk("first_rd_en", int'(fifo_rd_en), 1);
        k = 0;
        while (!m_valid && k < 10) begin
            step();
            k++;
        end
        chk("first_valid_latency", k, 2);
        wait_done(0, 100);
        chk("burst_span", hs_cyc[(hs0 + N - 1) % MS] - hs_cyc[hs0 % MS], N - 1);
        chk("rd_count", rd_cnt - rd0, N);
        chk("underrun_full", int'(underrun_count), 0);

        // Empty FIFO, one pixel every three cycles.
        stage(N);
        start_frame();
        for (int i = 0; i < N; i++) begin
            step(3);
            wr_ptr++;
        end
        wait_done(0, 200);
`ifdef STREAM_UNDERRUN_CNT_EN
        chk("underrun_nonzero", int'(underrun_count > 0), 1);
`else
        chk("underrun_disabled", int'(underrun_count), 0);
`endif

        // Surplus in the FIFO must stay there.
        stage(N + 4);
        wr_ptr = sp;
        rd0 = rd_cnt;
        start_frame();
        wait_done(0, 100);
        chk("fifo_leftover", wr_ptr - rd_ptr, 4);
        chk("rd_count_surplus", rd_cnt - rd0, N);
        step(10);
        chk("idle_no_read", int'(fifo_rd_en), 0);
        chk("leftover_kept", wr_ptr - rd_ptr, 4);

        // Stall pattern 1,0,0,1 consuming the leftovers first.
        rmode = 1;
        stage(4);
        wr_ptr = sp;
        start_frame();
        wait_done(0, 200);
        chk("fifo_drained", wr_ptr - rd_ptr, 0);

        // Random ready with random arrivals.
        rmode = 2;
        for (int f = 0; f < 3; f++) begin
            stage(N);
            start_frame();
            wait_done(1, 400);
        end

        // Extra frame_start mid-frame is ignored.
        stage(N);
        wr_ptr = sp;
        hs0 = hs_cnt;
        rd0 = rd_cnt;
        start_frame();
        step(3);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        wait_done(0, 200);
        chk("midstart_hs", hs_cnt - hs0, N);
        chk("midstart_rd", rd_cnt - rd0, N);
        chk("midstart_idle", int'(busy), 0);

        // Reset after the fifth handshake.
        rmode = 0;
        stage(N);
        wr_ptr = sp;
        hs0 = hs_cnt;
        start_frame();
        k = 0;
        while (hs_cnt - hs0 < 5 && k < 50) begin
            step();
            k++;
        end
        chk("reset_wait", int'(k < 50), 1);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_valid", int'(m_valid), 0);
        chk("mid_rst_data", int'(m_data), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_flags", int'({m_sof, m_eol, m_eof}), 0);
        chk("mid_rst_rd_en", int'(fifo_rd_en), 0);
        chk("mid_rst_frame_done", int'(frame_done), 0);
        chk("mid_rst_underrun", int'(underrun_count), 0);
        step(2);
        aresetn = 1'b1;
        step(2);
        stage(N);
        wr_ptr = sp;
        start_frame();
        wait_done(0, 100);
        chk("post_reset_drain", int'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
